// File: rtl/neuron_lut_loader_pkg.sv
// ---------------------------------------------------------------------------
// logicnet_pkg
//   Shared definitions for the LogicNet layer blocks:
//     - state_t  : IDLE / LOAD / ARMED states of the runtime-programmable neuron
//     - clog2    : width helper used to size table indices and counters
//     - DEFAULT_* : default neuron geometry shared by every layer block
// ---------------------------------------------------------------------------
package logicnet_pkg;

  localparam int DEFAULT_IN_BITS  = 32'd2;
  localparam int DEFAULT_FANIN    = 32'd3;
  localparam int DEFAULT_OUT_BITS = 32'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_t;

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int         result;
    logic [32:0] pow;
    result = 32'd0;
    for (int i = 0; i < 32; i++) begin
      pow = 33'd1 << i;
      if (pow < 33'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/neuron_lut_loader_if.sv
// ---------------------------------------------------------------------------
// neuron_lut_loader_if
//   Bundles the config stream and the lookup datapath of one neuron LUT.
//   Config : cfg_start, cfg_valid, cfg_data  (master -> slave)
//            cfg_ready, cfg_done             (slave -> master)
//   Lookup : M0, in_valid                    (master -> slave)
//            M1, out_valid                   (slave -> master)
//   Optional (LUT_CHECKSUM_EN): cfg_sum[15:0] (slave -> master)
//   Modports: master = table writer / layer driver, slave = neuron_lut_loader.
// ---------------------------------------------------------------------------
interface neuron_lut_loader_if
  import logicnet_pkg::*;
#(
  parameter int IN_BITS  = DEFAULT_IN_BITS,
  parameter int FANIN    = DEFAULT_FANIN,
  parameter int OUT_BITS = DEFAULT_OUT_BITS
);
  localparam int ADDR_W = FANIN * IN_BITS;

  logic                cfg_start;
  logic                cfg_valid;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_ready;
  logic                cfg_done;
  logic [ADDR_W-1:0]   M0;
  logic                in_valid;
  logic [OUT_BITS-1:0] M1;
  logic                out_valid;
`ifdef LUT_CHECKSUM_EN
  logic [15:0]         cfg_sum;

  modport master (
    output cfg_start, cfg_valid, cfg_data, M0, in_valid,
    input  cfg_ready, cfg_done, M1, out_valid, cfg_sum
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_data, M0, in_valid,
    output cfg_ready, cfg_done, M1, out_valid, cfg_sum
  );
`else
  modport master (
    output cfg_start, cfg_valid, cfg_data, M0, in_valid,
    input  cfg_ready, cfg_done, M1, out_valid
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_data, M0, in_valid,
    output cfg_ready, cfg_done, M1, out_valid
  );
`endif

endinterface

// File: rtl/neuron_lut_ram.sv
// ---------------------------------------------------------------------------
// neuron_lut_ram
//   DEPTH x DATA_W distributed RAM holding one neuron truth table.
//   Synchronous write port, asynchronous read port; the lookup register is
//   kept in the parent. Contents are deliberately not reset.
//   Ports: clk, we, waddr, wdata (write); raddr -> rdata (read).
// ---------------------------------------------------------------------------
module neuron_lut_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];

  // Table write, one entry per accepted config beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/neuron_lut_loader.sv
// ---------------------------------------------------------------------------
// neuron_lut_loader
//   Runtime-programmable LogicNet neuron. A FANIN x IN_BITS -> OUT_BITS truth
//   table is streamed in over the config port (entries in ascending address
//   order) and then served as registered, 1-cycle-latency lookups.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset (aborts any load)
//     bus    : neuron_lut_loader_if.slave (config stream + lookup datapath)
//     armed  : a complete table is loaded and lookups are served
//   Optional feature macro LUT_CHECKSUM_EN: drives bus.cfg_sum, the modulo
//   2^16 sum of entries accepted since the last cfg_start.
// ---------------------------------------------------------------------------
module neuron_lut_loader
  import logicnet_pkg::*;
#(
  parameter int IN_BITS  = DEFAULT_IN_BITS,
  parameter int FANIN    = DEFAULT_FANIN,
  parameter int OUT_BITS = DEFAULT_OUT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  neuron_lut_loader_if.slave    bus,
  output logic                  armed
);
  localparam int ADDR_W = FANIN * IN_BITS;
  localparam int DEPTH  = 1 << ADDR_W;
  // One spare bit so the count never wraps inside a load.
  localparam int CNT_W  = clog2(DEPTH) + 1;

  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    wr_cnt_r, wr_cnt_next_s;
  logic                wr_en_s;
  logic                done_next_s;
  logic                cfg_ready_r;
  logic                cfg_done_r;
  logic                armed_r;
  logic                out_valid_r;
  logic [OUT_BITS-1:0] m1_r;
  logic [OUT_BITS-1:0] rd_data_s;
  logic                lookup_fire_s;

  // Next-state, write-enable and counter logic of the load FSM.
  always_comb begin
    state_next_s  = state_r;
    wr_cnt_next_s = wr_cnt_r;
    wr_en_s       = 1'b0;
    done_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cfg_start) begin
          state_next_s  = LOAD;
          wr_cnt_next_s = '0;
        end else begin
          state_next_s  = IDLE;
        end
      end
      LOAD: begin
        // A restart wins over a coincident write, which is dropped.
        if (bus.cfg_start) begin
          state_next_s  = LOAD;
          wr_cnt_next_s = '0;
        end else if (bus.cfg_valid) begin
          wr_en_s       = 1'b1;
          wr_cnt_next_s = wr_cnt_r + CNT_W'(1);
          if (wr_cnt_r == CNT_W'(DEPTH - 1)) begin
            state_next_s = ARMED;
            done_next_s  = 1'b1;
          end else begin
            state_next_s = LOAD;
          end
        end else begin
          state_next_s  = LOAD;
        end
      end
      ARMED: begin
        if (bus.cfg_start) begin
          state_next_s  = LOAD;
          wr_cnt_next_s = '0;
        end else begin
          state_next_s  = ARMED;
        end
      end
      default: begin
        state_next_s  = IDLE;
        wr_cnt_next_s = '0;
      end
    endcase
  end

  // FSM state, write counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wr_cnt_r    <= '0;
      cfg_ready_r <= 1'b0;
      cfg_done_r  <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      wr_cnt_r    <= wr_cnt_next_s;
      cfg_ready_r <= (state_next_s == LOAD);
      cfg_done_r  <= done_next_s;
      armed_r     <= (state_next_s == ARMED);
    end
  end

  // Lookups are served on the current state, so a lookup issued together
  // with cfg_start in ARMED still reads the old, intact table.
  assign lookup_fire_s = bus.in_valid && (state_r == ARMED);

  // Lookup result register; M1 holds its value between lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      m1_r        <= '0;
    end else begin
      out_valid_r <= lookup_fire_s;
      if (lookup_fire_s) begin
        m1_r <= rd_data_s;
      end
    end
  end

  neuron_lut_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (OUT_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_cnt_r[ADDR_W-1:0]),
    .wdata (bus.cfg_data),
    .raddr (bus.M0),
    .rdata (rd_data_s)
  );

`ifdef LUT_CHECKSUM_EN
  logic [15:0] sum_r;

  // Running modulo-2^16 checksum of accepted entries, cleared by cfg_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= 16'd0;
    end else if (bus.cfg_start) begin
      sum_r <= 16'd0;
    end else if (wr_en_s) begin
      sum_r <= sum_r + 16'(bus.cfg_data);
    end else begin
      sum_r <= sum_r;
    end
  end

  assign bus.cfg_sum = sum_r;
`else
  // Checksum accumulator and port are not built in this configuration.
`endif

  assign bus.cfg_ready = cfg_ready_r;
  assign bus.cfg_done  = cfg_done_r;
  assign bus.M1        = m1_r;
  assign bus.out_valid = out_valid_r;
  assign armed         = armed_r;

endmodule

// File: tb/tb_neuron_lut_loader.sv
// ---------------------------------------------------------------------------
// tb_neuron_lut_loader
//   Directed bench for neuron_lut_loader. Inputs change on the falling edge,
//   outputs are sampled on the falling edge after the rising edge that
//   produced them.
// ---------------------------------------------------------------------------
module tb_neuron_lut_loader;

  logic clk;
  logic rst_n;
  logic armed;

  int checks;
  int errors;

  typedef struct {
    logic [5:0] m0;
    logic [1:0] exp_m1;
  } vec_t;

  vec_t vecs[6];

  neuron_lut_loader_if #(.IN_BITS(2), .FANIN(3), .OUT_BITS(2)) bus ();

  neuron_lut_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .armed (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Table content generators: 0 = addr%4, 1 = all 01, 2 = all 11, 3 = 3-addr%4.
  function automatic logic [1:0] entry_val(input int mode, input int addr);
    logic [1:0] v;
    case (mode)
      0:       v = 2'(addr % 4);
      1:       v = 2'b01;
      2:       v = 2'b11;
      default: v = 2'(3 - (addr % 4));
    endcase
    return v;
  endfunction

  // Pulse cfg_start, then stream n_writes entries. Returns cycles spent
  // streaming and the number of cfg_done pulses seen.
  task automatic do_load(input int mode, input bit toggle, input int n_writes,
                         input bit valid_on_start, output int cycles, output int done_cnt);
    int accepted;
    int i;
    bit acc;
    bus.cfg_start = 1'b1;
    bus.cfg_valid = valid_on_start;
    bus.cfg_data  = 2'b10;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    accepted = 0;
    i        = 0;
    done_cnt = 0;
    while (accepted < n_writes && i < 1000) begin
      bus.cfg_valid = toggle ? (i % 2 == 0) : 1'b1;
      bus.cfg_data  = entry_val(mode, accepted);
      acc = bus.cfg_valid && bus.cfg_ready;
      @(negedge clk);
      if (acc) accepted++;
      if (bus.cfg_done) done_cnt++;
      i++;
    end
    bus.cfg_valid = 1'b0;
    if (i >= 1000) begin
      check("load_timeout", 16'(accepted), 16'(n_writes));
    end
    @(negedge clk);
    if (bus.cfg_done) done_cnt++;
    cycles = i;
  endtask

  task automatic lookup_one(input string name, input logic [5:0] m0, input logic [1:0] exp);
    bus.in_valid = 1'b1;
    bus.M0       = m0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({name, "_ov"}, 16'(bus.out_valid), 16'd1);
    check({name, "_m1"}, 16'(bus.M1), 16'(exp));
  endtask

  // Back-to-back lookups from the vector table, then a hold check.
  task automatic run_table(input string name);
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        bus.in_valid = 1'b1;
        bus.M0       = vecs[k].m0;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 6) begin
        check({name, "_ov"}, 16'(bus.out_valid), 16'd1);
        check({name, "_m1"}, 16'(bus.M1), 16'(vecs[k].exp_m1));
      end else begin
        check({name, "_idle_ov"}, 16'(bus.out_valid), 16'd0);
        check({name, "_hold_m1"}, 16'(bus.M1), 16'(vecs[5].exp_m1));
      end
    end
  endtask

  initial begin
    int cyc;
    int dn;
    checks = 0;
    errors = 0;

    vecs[0] = '{6'b000011, 2'b11};
    vecs[1] = '{6'b000110, 2'b10};
    vecs[2] = '{6'b000000, 2'b00};
    vecs[3] = '{6'b111111, 2'b11};
    vecs[4] = '{6'b101101, 2'b01};
    vecs[5] = '{6'b010110, 2'b10};

    rst_n         = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 2'b00;
    bus.M0        = 6'b000000;
    bus.in_valid  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", 16'(bus.cfg_ready), 16'd0);
    check("rst_cfg_done",  16'(bus.cfg_done),  16'd0);
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_m1",        16'(bus.M1),        16'd0);
    check("rst_armed",     16'(armed),         16'd0);
    rst_n = 1'b1;

    // 1: lookup before any load is ignored.
    bus.in_valid = 1'b1;
    bus.M0       = 6'b000000;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    check("t1_out_valid", 16'(bus.out_valid), 16'd0);
    check("t1_armed",     16'(armed),         16'd0);
    check("t1_cfg_ready", 16'(bus.cfg_ready), 16'd0);

    // 2: continuous load of addr%4.
    do_load(0, 1'b0, 64, 1'b0, cyc, dn);
    check("t2_cycles", 16'(cyc), 16'd64);
    check("t2_done",   16'(dn),  16'd1);
    check("t2_armed",  16'(armed), 16'd1);
    check("t2_ready",  16'(bus.cfg_ready), 16'd0);
    run_table("t2");

    // 4: aborted partial load, restart with a coincident (dropped) write.
    do_load(2, 1'b0, 30, 1'b0, cyc, dn);
    check("t4_partial_done",  16'(dn),    16'd0);
    check("t4_partial_armed", 16'(armed), 16'd0);
    do_load(1, 1'b0, 64, 1'b1, cyc, dn);
    check("t4_done",  16'(dn),    16'd1);
    check("t4_armed", 16'(armed), 16'd1);
    for (int a = 0; a < 64; a++) begin
      lookup_one("t4_all", 6'(a), 2'b01);
    end

    // 5: reset during a load aborts it.
    do_load(2, 1'b0, 40, 1'b0, cyc, dn);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_armed", 16'(armed),         16'd0);
    check("t5_rst_ready", 16'(bus.cfg_ready), 16'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.M0       = 6'b000011;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    check("t5_ov",    16'(bus.out_valid), 16'd0);
    check("t5_ready", 16'(bus.cfg_ready), 16'd0);
    check("t5_m1",    16'(bus.M1),        16'd0);
    do_load(0, 1'b0, 64, 1'b0, cyc, dn);
    check("t5_done",  16'(dn),    16'd1);
    check("t5_armed", 16'(armed), 16'd1);
    run_table("t5");

    // cfg_start together with a lookup in ARMED: lookup completes on old table.
    bus.cfg_start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.M0        = 6'd7;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    check("race_ov",    16'(bus.out_valid), 16'd1);
    check("race_m1",    16'(bus.M1),        16'd3);
    check("race_armed", 16'(armed),         16'd0);
    check("race_ready", 16'(bus.cfg_ready), 16'd1);
    bus.M0 = 6'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("load_lookup_ov", 16'(bus.out_valid), 16'd0);

    // 3: load with cfg_valid toggling, table 3-addr%4.
    do_load(3, 1'b1, 64, 1'b0, cyc, dn);
    check("t3_cycles", 16'(cyc), 16'd127);
    check("t3_done",   16'(dn),  16'd1);
    check("t3_armed",  16'(armed), 16'd1);
`ifdef LUT_CHECKSUM_EN
    check("t3_sum", bus.cfg_sum, 16'd96);
`endif
    lookup_one("t3_last",  6'b111111, 2'b00);
    lookup_one("t3_first", 6'b000000, 2'b11);
    lookup_one("t3_mid",   6'b100101, 2'b10);

`ifdef LUT_CHECKSUM_EN
    // 6: checksum over an all-11 table, cleared by the next cfg_start.
    do_load(2, 1'b0, 64, 1'b0, cyc, dn);
    check("t6_sum", bus.cfg_sum, 16'd192);
    @(negedge clk);
    check("t6_sum_stable", bus.cfg_sum, 16'd192);
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    check("t6_sum_clr", bus.cfg_sum, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
